// File: rtl/sequential_divider_pkg.sv
// Shared constants for the iterative signed divider behind the ALU div select.
// DIV_LATENCY is the cycle count the control unit's DIV32 step relies on.
package sequential_divider_pkg;

  localparam int DIV_BITS    = 32;
  localparam int DIV_LATENCY = DIV_BITS;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/sequential_divider_div_step.sv
// One restoring division iteration on unsigned magnitudes.
// Shifts {pr, dq} left by one, then subtracts the divisor from the partial
// remainder when it fits and shifts the resulting quotient bit into dq.
module sequential_divider_div_step #(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] prIn,
  input  logic [BITS-1:0] dqIn,
  input  logic [BITS-1:0] divisor,
  output logic [BITS-1:0] prOut,
  output logic [BITS-1:0] dqOut
);

  logic [BITS:0]   shifted;
  logic [BITS-1:0] diff;
  logic            fits;

  // Trial subtraction is judged on the full BITS+1 shifted value; the low
  // BITS of the difference are exact whenever the divisor fits.
  always_comb begin
    shifted = {prIn, dqIn[BITS-1]};
    fits    = (shifted >= {1'b0, divisor});
    diff    = shifted[BITS-1:0] - divisor;
    if (fits) begin
      prOut = diff;
      dqOut = {dqIn[BITS-2:0], 1'b1};
    end else begin
      prOut = shifted[BITS-1:0];
      dqOut = {dqIn[BITS-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Iterative signed divider: one quotient bit per clock, fixed latency of BITS
// cycles from the start edge to the done cycle. quotient feeds LO, remainder
// feeds HI. Optional macro SEQUENTIAL_DIVIDER_DIV0_FLAG_EN adds a registered
// div_zero output valid in the done cycle.
module sequential_divider
  import sequential_divider_pkg::*;
#(
  parameter int BITS = DIV_BITS
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  output logic [BITS-1:0] quotient,
  output logic [BITS-1:0] remainder,
  output logic            busy,
  output logic            done
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
  ,
  output logic            div_zero
`endif
);

  localparam int              CW         = $clog2(BITS) + 1;
  localparam logic [CW-1:0]   LAST_COUNT = CW'(BITS - 1);
  localparam logic [CW-1:0]   COUNT_ONE  = CW'(1);

  logic [1:0]      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [BITS-1:0] partRem_q, partRem_d;
  logic [BITS-1:0] dqShift_q, dqShift_d;
  logic [BITS-1:0] divisorMag_q, divisorMag_d;
  logic [BITS-1:0] quotient_q, quotient_d;
  logic [BITS-1:0] remainder_q, remainder_d;
  logic            signQuot_q, signQuot_d;
  logic            signRem_q, signRem_d;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
  logic            divZero_q, divZero_d;
`endif

  logic [BITS-1:0] aMag, bMag;
  logic [BITS-1:0] stepPrIn, stepDqIn, stepDivisor;
  logic [BITS-1:0] stepPr, stepDq;
  logic [BITS-1:0] quotFixed, remFixed;
  logic            divByZero;

  // Operand magnitudes and the shared step input mux: a start edge feeds the
  // fresh operands, otherwise the step continues from the held registers.
  always_comb begin
    aMag        = a[BITS-1] ? ('0 - a) : a;
    bMag        = b[BITS-1] ? ('0 - b) : b;
    stepPrIn    = start ? '0   : partRem_q;
    stepDqIn    = start ? aMag : dqShift_q;
    stepDivisor = start ? bMag : divisorMag_q;
  end

  sequential_divider_div_step #(
    .BITS (BITS)
  ) u_step (
    .prIn    (stepPrIn),
    .dqIn    (stepDqIn),
    .divisor (stepDivisor),
    .prOut   (stepPr),
    .dqOut   (stepDq)
  );

  // Sign fix-up of the final iteration; a zero divisor leaves the raw
  // all-ones quotient untouched, while the remainder fix-up restores a.
  always_comb begin
    divByZero = (divisorMag_q == '0);
    quotFixed = (signQuot_q && !divByZero) ? ('0 - stepDq) : stepDq;
    remFixed  = signRem_q ? ('0 - stepPr) : stepPr;
  end

  // Next-state logic: start always (re)loads, RUN iterates until the last
  // count, where results are committed and the FSM enters DONE.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    partRem_d    = partRem_q;
    dqShift_d    = dqShift_q;
    divisorMag_d = divisorMag_q;
    quotient_d   = quotient_q;
    remainder_d  = remainder_q;
    signQuot_d   = signQuot_q;
    signRem_d    = signRem_q;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
    divZero_d    = divZero_q;
`endif
    if (start) begin
      state_d      = DIV_RUN;
      count_d      = COUNT_ONE;
      partRem_d    = stepPr;
      dqShift_d    = stepDq;
      divisorMag_d = bMag;
      signQuot_d   = a[BITS-1] ^ b[BITS-1];
      signRem_d    = a[BITS-1];
    end else begin
      case (state_q)
        DIV_RUN: begin
          partRem_d = stepPr;
          dqShift_d = stepDq;
          count_d   = count_q + COUNT_ONE;
          if (count_q == LAST_COUNT) begin
            state_d     = DIV_DONE;
            quotient_d  = quotFixed;
            remainder_d = remFixed;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
            divZero_d   = divByZero;
`endif
          end
        end
        DIV_DONE: state_d = DIV_IDLE;
        DIV_IDLE: state_d = DIV_IDLE;
        default:  state_d = DIV_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous clear taking priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= DIV_IDLE;
      count_q      <= '0;
      partRem_q    <= '0;
      dqShift_q    <= '0;
      divisorMag_q <= '0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      signQuot_q   <= 1'b0;
      signRem_q    <= 1'b0;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
      divZero_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      partRem_q    <= partRem_d;
      dqShift_q    <= dqShift_d;
      divisorMag_q <= divisorMag_d;
      quotient_q   <= quotient_d;
      remainder_q  <= remainder_d;
      signQuot_q   <= signQuot_d;
      signRem_q    <= signRem_d;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
      divZero_q    <= divZero_d;
`endif
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q == DIV_RUN);
  assign done      = (state_q == DIV_DONE);
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
  assign div_zero  = divZero_q;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: stimulus pushes expected results
// and the done cycle; a monitor pops and compares whenever done is seen.
// Honours SEQUENTIAL_DIVIDER_DIV0_FLAG_EN for the div_zero port.
module tb_sequential_divider;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] quotient, remainder;
  logic        busy, done;
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
  logic        divZero;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          doneCycle;
    string       name;
  } exp_t;

  exp_t  expQ[$];
  exp_t  popped;
  int    nVectors     = 0;
  int    nMiscompares = 0;
  int    cycle        = 0;
  bit    monitorOn    = 1'b0;

  sequential_divider dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .a         (a),
    .b         (b),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
    ,
    .div_zero  (divZero)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    nVectors++;
    if (actual !== required) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (monitorOn && done === 1'b1) begin
      if (expQ.size() == 0) begin
        nVectors++;
        nMiscompares++;
        $display("[TB] FAIL unexpected done at cycle %0d: got done=1, expected done=0", cycle);
      end else begin
        popped = expQ.pop_front();
        checkOutput({popped.name, " quotient"}, quotient, popped.q);
        checkOutput({popped.name, " remainder"}, remainder, popped.r);
        checkOutput({popped.name, " done cycle"}, 32'(cycle), 32'(popped.doneCycle));
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
        checkOutput({popped.name, " div_zero"}, {31'b0, divZero}, {31'b0, popped.dz});
`endif
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] q, input logic [31:0] r,
                               input logic dz, input bit push, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.q         = q;
      e.r         = r;
      e.dz        = dz;
      e.doneCycle = cycle + LAT;
      e.name      = name;
      expQ.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDrain(input string name, output int busyCycles);
    int budget;
    budget     = 0;
    busyCycles = 0;
    while (expQ.size() != 0 && budget < 80) begin
      @(negedge clk);
      if (busy === 1'b1) busyCycles++;
      budget++;
    end
    if (expQ.size() != 0) begin
      nVectors++;
      nMiscompares++;
      $display("[TB] FAIL %s timeout: got %0d pending results, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  localparam int NV = 10;
  logic [31:0] tA [NV] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd7,
                           32'hFFFFFFF9, 32'h80000000, 32'h7FFFFFFF, 32'd5, 32'd0};
  logic [31:0] tB [NV] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0,
                           32'd0, 32'hFFFFFFFF, 32'd1, 32'd10, 32'd3};
  logic [31:0] tQ [NV] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'd14, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0};
  logic [31:0] tR [NV] = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'hFFFFFFFE, 32'd7,
                           32'hFFFFFFF9, 32'd0, 32'd0, 32'd5, 32'd0};
  logic        tZ [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  string       tN [NV] = '{"pos", "neg dividend", "neg divisor", "both neg", "div0 pos",
                           "div0 neg", "overflow", "max by one", "small by big", "zero dividend"};

  initial begin
    int busyCnt;
    clr   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("reset quotient", quotient, 32'd0);
    checkOutput("reset remainder", remainder, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset done", {31'b0, done}, 32'd0);
    monitorOn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(tA[i], tB[i], tQ[i], tR[i], tZ[i], 1'b1, tN[i]);
      waitDrain(tN[i], busyCnt);
      checkOutput({tN[i], " busy cycles"}, 32'(busyCnt), 32'(LAT - 1));
    end

    // Restart mid-run: 100/7 aborted at t+10 by 50/5, single done at t+42.
    applyStimulus(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, "aborted");
    repeat (8) @(posedge clk);
    applyStimulus(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1'b1, "restart");
    waitDrain("restart", busyCnt);

    // Back-to-back: second start lands in the first operation's done cycle.
    applyStimulus(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 1'b1, "b2b first");
    repeat (30) @(posedge clk);
    applyStimulus(32'h80000000, 32'd7, 32'hEDB6DB6E, 32'hFFFFFFFE, 1'b0, 1'b1, "b2b second");
    waitDrain("b2b", busyCnt);

    // Clear in the middle of a run: outputs drop to zero, no done follows.
    applyStimulus(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, "cleared");
    repeat (12) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    checkOutput("clr quotient", quotient, 32'd0);
    checkOutput("clr remainder", remainder, 32'd0);
    checkOutput("clr busy", {31'b0, busy}, 32'd0);
    checkOutput("clr done", {31'b0, done}, 32'd0);
`ifdef SEQUENTIAL_DIVIDER_DIV0_FLAG_EN
    checkOutput("clr div_zero", {31'b0, divZero}, 32'd0);
`endif
    repeat (40) @(negedge clk);
    checkOutput("idle after clr busy", {31'b0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
